mbus_ctrl_gen2: RTL and testbench

- Parametrised second-generation MBus bus controller.
- Detects a transaction start on the bus data line, generates the bus clock by dividing the system clock, and sequences arbitration and drive/latch bit phases.
- Detects the in-band bus-reset signature (data toggling inside a bit period) and holds the bus in reset for a programmable length.
- Adds a runtime clock divisor, configurable reset-detect threshold and hold length, and status outputs (busy, reset pulse, bit counter).

---
 rtl/mbus_ctrl_gen2_if.sv | 24 ++
 rtl/mbus_ctrl_gen2.sv | 142 ++++++++++++++
 tb/tb_mbus_ctrl_gen2.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbus_ctrl_gen2_if.sv
// Bus-side signal bundle for the gen2 MBus controller.
// The controller takes the master modport; the upstream/downstream side takes slave.
interface mbus_ctrl_gen2_if #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 8
);
  logic             IN;
  logic [DIV_W-1:0] DIV;
  logic             OUT;
  logic             CLK_OUT;
  logic             BUSY;
  logic             BUS_RESET_PULSE;
  logic [CNT_W-1:0] BIT_COUNT;

  modport master (
    input  IN, DIV,
    output OUT, CLK_OUT, BUSY, BUS_RESET_PULSE, BIT_COUNT
  );

  modport slave (
    output IN, DIV,
    input  OUT, CLK_OUT, BUSY, BUS_RESET_PULSE, BIT_COUNT
  );
endinterface

// File: rtl/mbus_ctrl_gen2.sv
// Second-generation MBus controller: start detect, divided bus clock, arbitration and
// drive/latch phases, in-band bus-reset detection with a programmable hold.
module mbus_ctrl_gen2 #(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned RST_DET_N = 1,
  parameter int unsigned RST_HOLD  = 4,
  parameter int unsigned CNT_W     = 8
) (
  input logic              CLK_IN,
  input logic              RESET,
  mbus_ctrl_gen2_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, WAIT_HALF, ARB, DRIVE, LATCH, BUS_RESET
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic             phase;
  logic             clk_out;
  logic             busy;
  logic             pulse;
  logic             drive_first;
  logic [1:0]       hist;
  logic [1:0]       warm;
  logic [2:0]       mis;
  logic [3:0]       hold;
  logic [CNT_W-1:0] bit_count;

  logic [DIV_W-1:0] eff_div;
  logic             tc;
  logic             second;
  logic [2:0]       mis_nx;
  logic             detect;

  always_comb begin
    eff_div = (bus.DIV == '0) ? DIV_W'(1) : bus.DIV;
    tc      = (state != IDLE) && (cnt == div_q - DIV_W'(1));
    second  = tc && phase;
    mis_nx  = (hist[1] != hist[0]) ? mis + 3'd1 : '0;
    detect  = (state == DRIVE) && drive_first && (warm == 2'd2) &&
              (mis_nx == 3'(RST_DET_N));
  end

  always_ff @(posedge CLK_IN or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      div_q       <= '0;
      cnt         <= '0;
      phase       <= 1'b0;
      clk_out     <= 1'b1;
      busy        <= 1'b0;
      pulse       <= 1'b0;
      drive_first <= 1'b0;
      hist        <= '0;
      warm        <= '0;
      mis         <= '0;
      hold        <= '0;
      bit_count   <= '0;
    end else begin
      pulse       <= 1'b0;
      drive_first <= 1'b0;
      // The divider free-runs through every non-idle state, including BUS_RESET.
      if (tc) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        phase   <= ~phase;
      end else if (state != IDLE) begin
        cnt <= cnt + DIV_W'(1);
      end

      case (state)
        IDLE: begin
          clk_out <= 1'b1;
          cnt     <= '0;
          phase   <= 1'b0;
          if (!bus.IN) begin
            state     <= WAIT_HALF;
            busy      <= 1'b1;
            div_q     <= eff_div;
            bit_count <= '0;
          end
        end
        WAIT_HALF: if (second) state <= ARB;
        ARB: begin
          if (second) begin
            state       <= DRIVE;
            drive_first <= 1'b1;
          end
        end
        DRIVE: begin
          if (drive_first && (warm == 2'd2)) mis <= mis_nx;
          if (second) begin
            hist  <= {hist[0], bus.IN};
            state <= LATCH;
            if (warm != 2'd2) warm <= warm + 2'd1;
          end
          // Detection overrides the phase advance; the history shift above still lands.
          if (detect) begin
            state <= BUS_RESET;
            pulse <= 1'b1;
          end
        end
        LATCH: begin
          if (second) begin
            hist        <= {hist[0], bus.IN};
            state       <= DRIVE;
            drive_first <= 1'b1;
            if (bit_count != '1) bit_count <= bit_count + CNT_W'(1);
          end
        end
        BUS_RESET: begin
          if (second) begin
            if (hold == 4'(RST_HOLD - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              hold  <= '0;
              mis   <= '0;
              warm  <= '0;
              hist  <= '0;
            end else begin
              hold <= hold + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.OUT             = (state inside {DRIVE, LATCH, BUS_RESET}) ? bus.IN : 1'b1;
  assign bus.CLK_OUT         = clk_out;
  assign bus.BUSY            = busy;
  assign bus.BUS_RESET_PULSE = pulse;
  assign bus.BIT_COUNT       = bit_count;

endmodule

// File: tb/tb_mbus_ctrl_gen2.sv
// Directed bench for mbus_ctrl_gen2: two instances (detect threshold 1 and 3) share
// clock, reset and bus inputs; each scenario task checks the relevant instance.
module tb_mbus_ctrl_gen2;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       tb_in  = 1'b1;
  logic [7:0] tb_div = 8'd10;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int e0    = 0;

  mbus_ctrl_gen2_if #(.DIV_W(8), .CNT_W(8)) bus1 ();
  mbus_ctrl_gen2_if #(.DIV_W(8), .CNT_W(8)) bus3 ();

  assign bus1.IN  = tb_in;
  assign bus1.DIV = tb_div;
  assign bus3.IN  = tb_in;
  assign bus3.DIV = tb_div;

  mbus_ctrl_gen2 #(.DIV_W(8), .RST_DET_N(1), .RST_HOLD(4), .CNT_W(8)) u_dut1 (
    .CLK_IN (clk),
    .RESET  (rst_n),
    .bus    (bus1)
  );

  mbus_ctrl_gen2 #(.DIV_W(8), .RST_DET_N(3), .RST_HOLD(4), .CNT_W(8)) u_dut3 (
    .CLK_IN (clk),
    .RESET  (rst_n),
    .bus    (bus3)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Advance to edge e0+t (relative to the start-detect edge).
  task automatic to_cyc(input int t);
    while (cyc < e0 + t) tick(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tb_in = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic start_txn();
    tb_in = 1'b0;
    tick(1);
    e0    = cyc;
    tb_in = 1'b1;
  endtask

  task automatic test_reset();
    tick(2);
    total++;
    if ({bus1.BUSY, bus1.CLK_OUT, bus1.OUT, bus1.BUS_RESET_PULSE} !== 4'b0110) begin
      bad++;
      $display("FAIL reset_flags1: got %b want 0110",
               {bus1.BUSY, bus1.CLK_OUT, bus1.OUT, bus1.BUS_RESET_PULSE});
    end
    total++;
    if (bus1.BIT_COUNT !== 8'd0) begin
      bad++; $display("FAIL reset_count1: got %0d want 0", bus1.BIT_COUNT);
    end
    total++;
    if ({bus3.BUSY, bus3.CLK_OUT, bus3.OUT, bus3.BUS_RESET_PULSE} !== 4'b0110) begin
      bad++;
      $display("FAIL reset_flags3: got %b want 0110",
               {bus3.BUSY, bus3.CLK_OUT, bus3.OUT, bus3.BUS_RESET_PULSE});
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_start_phases();
    tb_div = 8'd10;
    do_reset();
    start_txn();
    total++;
    if ({bus1.BUSY, bus1.CLK_OUT} !== 2'b11) begin
      bad++; $display("FAIL start_busy: got %b want 11", {bus1.BUSY, bus1.CLK_OUT});
    end
    to_cyc(9);
    total++;
    if (bus1.CLK_OUT !== 1'b1) begin
      bad++; $display("FAIL first_fall_early: got %b want 1", bus1.CLK_OUT);
    end
    to_cyc(10);
    total++;
    if (bus1.CLK_OUT !== 1'b0) begin
      bad++; $display("FAIL first_fall: got %b want 0", bus1.CLK_OUT);
    end
    to_cyc(20);
    total++;
    if ({bus1.BUSY, bus1.CLK_OUT} !== 2'b11) begin
      bad++; $display("FAIL wait_half_end: got %b want 11", {bus1.BUSY, bus1.CLK_OUT});
    end
    tb_div = 8'd3;
    tb_in  = 1'b0;
    to_cyc(39);
    total++;
    if ({bus1.OUT, bus1.CLK_OUT} !== 2'b10) begin
      bad++; $display("FAIL arb_out: got %b want 10", {bus1.OUT, bus1.CLK_OUT});
    end
    to_cyc(40);
    total++;
    if ({bus1.OUT, bus1.CLK_OUT} !== 2'b01) begin
      bad++; $display("FAIL drive_entry: got %b want 01", {bus1.OUT, bus1.CLK_OUT});
    end
    tb_in = 1'b1;
    #1;
    total++;
    if (bus1.OUT !== 1'b1) begin
      bad++; $display("FAIL drive_follow: got %b want 1", bus1.OUT);
    end
  endtask

  task automatic test_div_edge();
    for (int dv = 0; dv < 2; dv++) begin
      tb_div = 8'(dv);
      do_reset();
      start_txn();
      for (int t = 1; t <= 4; t++) begin
        to_cyc(t);
        total++;
        if (bus1.CLK_OUT !== ((t % 2) == 0)) begin
          bad++;
          $display("FAIL div%0d_toggle t=%0d: got %b want %b", dv, t, bus1.CLK_OUT,
                   ((t % 2) == 0));
        end
      end
    end
    tb_div = 8'd2;
    do_reset();
    start_txn();
    tb_div = 8'd3;
    for (int t = 1; t <= 6; t++) begin
      to_cyc(t);
      total++;
      if (bus1.CLK_OUT !== (((t / 2) % 2) == 0)) begin
        bad++;
        $display("FAIL div_change t=%0d: got %b want %b", t, bus1.CLK_OUT,
                 (((t / 2) % 2) == 0));
      end
    end
  endtask

  task automatic test_bit_count();
    tb_div = 8'd2;
    do_reset();
    start_txn();
    to_cyc(15);
    total++;
    if (bus1.BIT_COUNT !== 8'd0) begin
      bad++; $display("FAIL cnt_pre: got %0d want 0", bus1.BIT_COUNT);
    end
    to_cyc(16);
    total++;
    if (bus1.BIT_COUNT !== 8'd1) begin
      bad++; $display("FAIL cnt_first: got %0d want 1", bus1.BIT_COUNT);
    end
    to_cyc(2047);
    total++;
    if (bus1.BIT_COUNT !== 8'd254) begin
      bad++; $display("FAIL cnt_254: got %0d want 254", bus1.BIT_COUNT);
    end
    to_cyc(2048);
    total++;
    if (bus1.BIT_COUNT !== 8'd255) begin
      bad++; $display("FAIL cnt_255: got %0d want 255", bus1.BIT_COUNT);
    end
    to_cyc(2408);
    total++;
    if (bus1.BIT_COUNT !== 8'd255) begin
      bad++; $display("FAIL cnt_sat: got %0d want 255", bus1.BIT_COUNT);
    end
    to_cyc(2412);
    tb_in = 1'b0;
    to_cyc(2416);
    total++;
    if ({bus1.BUSY, bus1.BUS_RESET_PULSE} !== 2'b10) begin
      bad++; $display("FAIL cnt_prerst: got %b want 10", {bus1.BUSY, bus1.BUS_RESET_PULSE});
    end
    to_cyc(2417);
    total++;
    if (bus1.BUS_RESET_PULSE !== 1'b1) begin
      bad++; $display("FAIL cnt_rst_pulse: got %b want 1", bus1.BUS_RESET_PULSE);
    end
    tb_in = 1'b1;
    to_cyc(2432);
    total++;
    if ({bus1.BUSY, bus1.CLK_OUT, bus1.BIT_COUNT} !== {2'b01, 8'd255}) begin
      bad++;
      $display("FAIL cnt_idle_hold: got busy=%b clk=%b cnt=%0d want busy=0 clk=1 cnt=255",
               bus1.BUSY, bus1.CLK_OUT, bus1.BIT_COUNT);
    end
    tick(2);
    start_txn();
    total++;
    if ({bus1.BUSY, bus1.BIT_COUNT} !== {1'b1, 8'd0}) begin
      bad++;
      $display("FAIL cnt_clear_on_start: got busy=%b cnt=%0d want busy=1 cnt=0",
               bus1.BUSY, bus1.BIT_COUNT);
    end
  endtask

  task automatic test_bus_reset();
    tb_div = 8'd10;
    do_reset();
    start_txn();
    to_cyc(100);
    tb_in = 1'b0;
    to_cyc(120);
    total++;
    if ({bus1.BUSY, bus1.BUS_RESET_PULSE, bus1.OUT} !== 3'b100) begin
      bad++;
      $display("FAIL br_check_cycle: got %b want 100",
               {bus1.BUSY, bus1.BUS_RESET_PULSE, bus1.OUT});
    end
    to_cyc(121);
    total++;
    if ({bus1.BUS_RESET_PULSE, bus1.OUT} !== 2'b10) begin
      bad++; $display("FAIL br_pulse: got %b want 10", {bus1.BUS_RESET_PULSE, bus1.OUT});
    end
    tb_in = 1'b1;
    #1;
    total++;
    if (bus1.OUT !== 1'b1) begin
      bad++; $display("FAIL br_out_follow: got %b want 1", bus1.OUT);
    end
    to_cyc(122);
    total++;
    if (bus1.BUS_RESET_PULSE !== 1'b0) begin
      bad++; $display("FAIL br_pulse_width: got %b want 0", bus1.BUS_RESET_PULSE);
    end
    to_cyc(129);
    total++;
    if (bus1.CLK_OUT !== 1'b1) begin
      bad++; $display("FAIL br_phase_hi: got %b want 1", bus1.CLK_OUT);
    end
    to_cyc(130);
    total++;
    if (bus1.CLK_OUT !== 1'b0) begin
      bad++; $display("FAIL br_phase_lo: got %b want 0", bus1.CLK_OUT);
    end
    to_cyc(199);
    total++;
    if (bus1.BUSY !== 1'b1) begin
      bad++; $display("FAIL br_hold_len: got %b want 1", bus1.BUSY);
    end
    tb_in = 1'b0;
    to_cyc(200);
    total++;
    if ({bus1.BUSY, bus1.OUT, bus1.CLK_OUT} !== 3'b011) begin
      bad++;
      $display("FAIL br_exit_idle: got %b want 011", {bus1.BUSY, bus1.OUT, bus1.CLK_OUT});
    end
    to_cyc(201);
    total++;
    if (bus1.BUSY !== 1'b1) begin
      bad++; $display("FAIL br_restart: got %b want 1", bus1.BUSY);
    end
    tb_in = 1'b1;
  endtask

  // Drives per-bit DRIVE/LATCH sample values (DIV=2 timing) and counts pulses seen.
  task automatic drive_pattern(input logic [7:0] d, input logic [7:0] l, input int last,
                               output int pulses);
    pulses = 0;
    for (int t = 1; t <= last; t++) begin
      to_cyc(t);
      if (bus3.BUS_RESET_PULSE === 1'b1) pulses++;
      if (t >= 8 && ((t - 8) % 8) == 0)
        tb_in = ((t - 8) / 8 < 8) ? d[(t - 8) / 8] : 1'b1;
      else if (t >= 12 && ((t - 12) % 8) == 0)
        tb_in = ((t - 12) / 8 < 8) ? l[(t - 12) / 8] : 1'b1;
    end
  endtask

  task automatic test_threshold();
    int pulses;
    tb_div = 8'd2;
    do_reset();
    start_txn();
    drive_pattern(8'b1101_1011, 8'b1010_1101, 64, pulses);
    total++;
    if (pulses !== 0 || bus3.BUSY !== 1'b1) begin
      bad++; $display("FAIL thr_no_early: got pulses=%0d busy=%b want 0 1", pulses, bus3.BUSY);
    end
    to_cyc(65);
    total++;
    if (bus3.BUS_RESET_PULSE !== 1'b1) begin
      bad++; $display("FAIL thr_third_mismatch: got %b want 1", bus3.BUS_RESET_PULSE);
    end
    tb_in = 1'b1;
    to_cyc(79);
    total++;
    if (bus3.BUSY !== 1'b1) begin
      bad++; $display("FAIL thr_hold1_len: got %b want 1", bus3.BUSY);
    end
    to_cyc(80);
    total++;
    if (bus3.BUSY !== 1'b0) begin
      bad++; $display("FAIL thr_hold1_exit: got %b want 0", bus3.BUSY);
    end
    tick(2);
    start_txn();
    drive_pattern(8'b1111_1011, 8'b1111_0101, 40, pulses);
    total++;
    if (pulses !== 0) begin
      bad++; $display("FAIL thr2_no_early: got %0d want 0", pulses);
    end
    to_cyc(41);
    total++;
    if (bus3.BUS_RESET_PULSE !== 1'b1) begin
      bad++; $display("FAIL thr2_pulse: got %b want 1", bus3.BUS_RESET_PULSE);
    end
    tb_in = 1'b1;
    to_cyc(55);
    total++;
    if (bus3.BUSY !== 1'b1) begin
      bad++; $display("FAIL thr2_hold_len: got %b want 1", bus3.BUSY);
    end
    to_cyc(56);
    total++;
    if (bus3.BUSY !== 1'b0) begin
      bad++; $display("FAIL thr2_hold_exit: got %b want 0", bus3.BUSY);
    end
  endtask

  task automatic test_async_reset();
    tb_div = 8'd10;
    do_reset();
    start_txn();
    to_cyc(111);
    tb_in = 1'b0;
    to_cyc(112);
    total++;
    if ({bus1.CLK_OUT, bus1.OUT, bus1.BIT_COUNT} !== {2'b00, 8'd1}) begin
      bad++;
      $display("FAIL ar_pre: got clk=%b out=%b cnt=%0d want clk=0 out=0 cnt=1",
               bus1.CLK_OUT, bus1.OUT, bus1.BIT_COUNT);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({bus1.BUSY, bus1.CLK_OUT, bus1.OUT, bus1.BUS_RESET_PULSE} !== 4'b0110) begin
      bad++;
      $display("FAIL ar_async: got %b want 0110",
               {bus1.BUSY, bus1.CLK_OUT, bus1.OUT, bus1.BUS_RESET_PULSE});
    end
    total++;
    if (bus1.BIT_COUNT !== 8'd0) begin
      bad++; $display("FAIL ar_count: got %0d want 0", bus1.BIT_COUNT);
    end
    tb_in = 1'b1;
    #2 rst_n = 1'b1;
    tick(30);
    total++;
    if ({bus1.BUSY, bus1.CLK_OUT, bus1.OUT} !== 3'b011) begin
      bad++; $display("FAIL ar_stay_idle: got %b want 011", {bus1.BUSY, bus1.CLK_OUT, bus1.OUT});
    end
  endtask

  initial begin
    test_reset();
    test_start_phases();
    test_div_edge();
    test_bit_count();
    test_bus_reset();
    test_threshold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
